// File: rtl/eth_tx_arb_if.sv
// 64-bit AXI-Stream beat bundle used on both arbiter inputs and the merged MAC-side output.
// master drives the beat and samples tready; slave samples the beat and drives tready.
interface eth_tx_arb_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_arb.sv
// Two-port packet arbiter onto the 10G MAC stream: one idle arbitration cycle, then a zero-latency pass-through.
// The granted port sees m_axis tready directly; the other port is held off until tlast transfers.
module eth_tx_arb #(
  parameter int unsigned RR_EN = 1,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk156,
  input  logic             sys_rst,
  eth_tx_arb_if.slave      s0_axis,
  eth_tx_arb_if.slave      s1_axis,
  eth_tx_arb_if.master     m_axis,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic             busy
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_P0   = 2'd1,
    ARB_P1   = 2'd2
  } arb_state_t;

  arb_state_t state;
  logic       last_grant;
  logic       p0_done;
  logic       p1_done;

  assign p0_done = (state == ARB_P0) && s0_axis.tvalid && m_axis.tready && s0_axis.tlast;
  assign p1_done = (state == ARB_P1) && s1_axis.tvalid && m_axis.tready && s1_axis.tlast;

  // The grant is only ever changed from IDLE, so a packet is never split by the other port.
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state      <= ARB_IDLE;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (s0_axis.tvalid && s1_axis.tvalid) begin
            busy <= 1'b1;
            if ((RR_EN != 0) && !last_grant) begin
              state <= ARB_P1;
            end else begin
              state <= ARB_P0;
            end
          end else if (s0_axis.tvalid) begin
            state <= ARB_P0;
            busy  <= 1'b1;
          end else if (s1_axis.tvalid) begin
            state <= ARB_P1;
            busy  <= 1'b1;
          end
        end
        ARB_P0: begin
          if (p0_done) begin
            state      <= ARB_IDLE;
            busy       <= 1'b0;
            last_grant <= 1'b0;
            pkt_cnt0   <= pkt_cnt0 + CNT_W'(1);
          end
        end
        ARB_P1: begin
          if (p1_done) begin
            state      <= ARB_IDLE;
            busy       <= 1'b0;
            last_grant <= 1'b1;
            pkt_cnt1   <= pkt_cnt1 + CNT_W'(1);
          end
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    m_axis.tvalid  = 1'b0;
    m_axis.tdata   = '0;
    m_axis.tkeep   = '0;
    m_axis.tlast   = 1'b0;
    m_axis.tuser   = 1'b0;
    s0_axis.tready = 1'b0;
    s1_axis.tready = 1'b0;
    case (state)
      ARB_P0: begin
        m_axis.tvalid  = s0_axis.tvalid;
        m_axis.tdata   = s0_axis.tdata;
        m_axis.tkeep   = s0_axis.tkeep;
        m_axis.tlast   = s0_axis.tlast;
        m_axis.tuser   = s0_axis.tuser;
        s0_axis.tready = m_axis.tready;
      end
      ARB_P1: begin
        m_axis.tvalid  = s1_axis.tvalid;
        m_axis.tdata   = s1_axis.tdata;
        m_axis.tkeep   = s1_axis.tkeep;
        m_axis.tlast   = s1_axis.tlast;
        m_axis.tuser   = s1_axis.tuser;
        s1_axis.tready = m_axis.tready;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: a round-robin instance (CNT_W=4) and a fixed-priority instance share one stimulus source.
module tb_eth_tx_arb;
  logic clk156 = 1'b0;
  always #3 clk156 = ~clk156;

  logic        sys_rst;
  logic        s0_vld, s1_vld, m_rdy;
  logic [63:0] s0_dat, s1_dat;
  logic [7:0]  s0_keep, s1_keep;
  logic        s0_last, s1_last, s0_user, s1_user;
  logic [3:0]  cnt0_r, cnt1_r;
  logic [31:0] cnt0_f, cnt1_f;
  logic        busy_r, busy_f;

  eth_tx_arb_if s0r();
  eth_tx_arb_if s1r();
  eth_tx_arb_if mr();
  eth_tx_arb_if s0f();
  eth_tx_arb_if s1f();
  eth_tx_arb_if mf();

  assign s0r.tvalid = s0_vld;  assign s0r.tdata = s0_dat;  assign s0r.tkeep = s0_keep;
  assign s0r.tlast  = s0_last; assign s0r.tuser = s0_user;
  assign s1r.tvalid = s1_vld;  assign s1r.tdata = s1_dat;  assign s1r.tkeep = s1_keep;
  assign s1r.tlast  = s1_last; assign s1r.tuser = s1_user;
  assign s0f.tvalid = s0_vld;  assign s0f.tdata = s0_dat;  assign s0f.tkeep = s0_keep;
  assign s0f.tlast  = s0_last; assign s0f.tuser = s0_user;
  assign s1f.tvalid = s1_vld;  assign s1f.tdata = s1_dat;  assign s1f.tkeep = s1_keep;
  assign s1f.tlast  = s1_last; assign s1f.tuser = s1_user;
  assign mr.tready  = m_rdy;
  assign mf.tready  = m_rdy;

  eth_tx_arb #(.RR_EN(1), .CNT_W(4)) dut_rr (
    .clk156(clk156), .sys_rst(sys_rst), .s0_axis(s0r), .s1_axis(s1r), .m_axis(mr),
    .pkt_cnt0(cnt0_r), .pkt_cnt1(cnt1_r), .busy(busy_r));

  eth_tx_arb #(.RR_EN(0)) dut_fp (
    .clk156(clk156), .sys_rst(sys_rst), .s0_axis(s0f), .s1_axis(s1f), .m_axis(mf),
    .pkt_cnt0(cnt0_f), .pkt_cnt1(cnt1_f), .busy(busy_f));

  int   checks = 0;
  int   passed = 0;
  int   b0, k0, b1, k1, gap0, gap_at;
  logic hs0, hs1, en0, en1, use_fp;

  function automatic logic [63:0] exp_dat(input int p, input int k, input int b);
    return {8'hA5, p[7:0], k[15:0], b[31:0]};
  endfunction
  function automatic logic [7:0] exp_keep(input int b, input int n);
    return (b == n - 1) ? 8'h0F : 8'hFF;
  endfunction
  function automatic logic exp_last(input int b, input int n);
    return (b == n - 1);
  endfunction
  function automatic logic exp_user(input int p, input int b);
    return p[0] ^ b[0];
  endfunction

  task automatic src_reset();
    b0 = 0; k0 = 0; b1 = 0; k1 = 0; hs0 = 0; hs1 = 0; gap0 = 0; gap_at = 0;
  endtask

  task automatic do_reset();
    @(posedge clk156); #1;
    sys_rst = 1'b1; s0_vld = 1'b0; s1_vld = 1'b0; m_rdy = 1'b1;
    repeat (2) @(posedge clk156);
    #1 sys_rst = 1'b0;
  endtask

  // One clock of the packet sources: advance on the last handshake, present the next beat, sample at negedge.
  task automatic cycle_src(input int n, input logic rdy);
    @(posedge clk156); #1;
    if (hs0) begin b0++; if (b0 == n) begin b0 = 0; k0++; end end
    if (hs1) begin b1++; if (b1 == n) begin b1 = 0; k1++; end end
    m_rdy = rdy;
    if (en0 && gap0 > 0 && b0 == gap_at) begin
      s0_vld = 1'b0; gap0--;
    end else begin
      s0_vld = en0; s0_dat = exp_dat(0, k0, b0); s0_keep = exp_keep(b0, n);
      s0_last = exp_last(b0, n); s0_user = exp_user(0, b0);
    end
    s1_vld = en1; s1_dat = exp_dat(1, k1, b1); s1_keep = exp_keep(b1, n);
    s1_last = exp_last(b1, n); s1_user = exp_user(1, b1);
    @(negedge clk156);
    hs0 = s0_vld && (use_fp ? s0f.tready : s0r.tready);
    hs1 = s1_vld && (use_fp ? s1f.tready : s1r.tready);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk156);
    checks++;
    if ({busy_r, mr.tvalid, s0r.tready, s1r.tready} !== 4'b0000)
      $display("FAIL reset_ctl: got %b want 0000", {busy_r, mr.tvalid, s0r.tready, s1r.tready});
    else passed++;
    checks++;
    if ({cnt0_r, cnt1_r} !== 8'h00) $display("FAIL reset_cnt: got %h want 00", {cnt0_r, cnt1_r});
    else passed++;
    checks++;
    if ({mr.tdata, mr.tkeep, mr.tlast, mr.tuser} !== 74'b0)
      $display("FAIL reset_bus: got %h want 0", {mr.tdata, mr.tkeep, mr.tlast, mr.tuser});
    else passed++;
    checks++;
    if ({busy_f, mf.tvalid, s0f.tready, s1f.tready, cnt0_f, cnt1_f} !== 68'b0)
      $display("FAIL reset_fp: got %h want 0", {busy_f, mf.tvalid, s0f.tready, s1f.tready, cnt0_f, cnt1_f});
    else passed++;
  endtask

  task automatic test_single_port();
    logic [76:0] obs, exp;
    do_reset(); src_reset(); use_fp = 0; en0 = 1; en1 = 0;
    cycle_src(6, 1'b1);
    checks++;
    if ({mr.tvalid, mr.tdata, mr.tkeep, mr.tlast, mr.tuser, busy_r} !== 76'b0)
      $display("FAIL single_latency: got tvalid=%b busy=%b tdata=%h want all 0", mr.tvalid, busy_r, mr.tdata);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      cycle_src(6, 1'b1);
      obs = {mr.tvalid, mr.tdata, mr.tkeep, mr.tlast, mr.tuser, s0r.tready, busy_r};
      exp = {1'b1, exp_dat(0, 0, i), exp_keep(i, 6), exp_last(i, 6), exp_user(0, i), 1'b1, 1'b1};
      checks++;
      if (obs !== exp) $display("FAIL single_beat%0d: got %h want %h", i, obs, exp);
      else passed++;
    end
    en0 = 0;
    cycle_src(6, 1'b1);
    checks++;
    if ({busy_r, mr.tvalid} !== 2'b00) $display("FAIL single_done: busy/tvalid got %b want 00", {busy_r, mr.tvalid});
    else passed++;
    checks++;
    if (cnt0_r !== 4'd1) $display("FAIL single_cnt0: got %0d want 1", cnt0_r);
    else passed++;
    checks++;
    if (cnt1_r !== 4'd0) $display("FAIL single_cnt1: got %0d want 0", cnt1_r);
    else passed++;
  endtask

  task automatic test_round_robin();
    int nb, pk, port, bt;
    logic expect_idle;
    logic [73:0] obs, exp;
    do_reset(); src_reset(); use_fp = 0; en0 = 1; en1 = 1;
    nb = 0; expect_idle = 0;
    for (int c = 0; c < 100; c++) begin
      cycle_src(3, 1'b1);
      if (expect_idle) begin
        checks++;
        if (mr.tvalid !== 1'b0) $display("FAIL rr_gap after beat %0d: tvalid got %b want 0", nb, mr.tvalid);
        else passed++;
        expect_idle = 0;
        if (nb == 12) break;
      end
      if (mr.tvalid === 1'b1 && mr.tready === 1'b1) begin
        pk = nb / 3; port = pk % 2; bt = nb % 3;
        obs = {mr.tdata, mr.tkeep, mr.tlast, mr.tuser};
        exp = {exp_dat(port, pk / 2, bt), exp_keep(bt, 3), exp_last(bt, 3), exp_user(port, bt)};
        checks++;
        if (obs !== exp) $display("FAIL rr_beat%0d: got %h want %h", nb, obs, exp);
        else passed++;
        if (mr.tlast === 1'b1) expect_idle = 1;
        nb++;
      end
    end
    checks++;
    if (nb !== 12) $display("FAIL rr_beats: got %0d want 12", nb);
    else passed++;
    checks++;
    if (cnt0_r !== 4'd2) $display("FAIL rr_cnt0: got %0d want 2", cnt0_r);
    else passed++;
    checks++;
    if (cnt1_r !== 4'd2) $display("FAIL rr_cnt1: got %0d want 2", cnt1_r);
    else passed++;
  endtask

  task automatic test_fixed_priority();
    int nb, bad_s1, bad_dat;
    do_reset(); src_reset(); use_fp = 1; en0 = 1; en1 = 1;
    nb = 0; bad_s1 = 0; bad_dat = 0;
    for (int c = 0; c < 40; c++) begin
      cycle_src(3, 1'b1);
      if (s1f.tready !== 1'b0) bad_s1++;
      if (mf.tvalid === 1'b1 && mf.tready === 1'b1) begin
        if ({mf.tdata, mf.tlast} !== {exp_dat(0, nb / 3, nb % 3), exp_last(nb % 3, 3)}) bad_dat++;
        nb++;
      end
    end
    checks++;
    if (bad_s1 !== 0) $display("FAIL fp_s1_tready: high on %0d cycles want 0", bad_s1);
    else passed++;
    checks++;
    if (bad_dat !== 0) $display("FAIL fp_data: %0d foreign/wrong beats want 0", bad_dat);
    else passed++;
    checks++;
    if (nb !== 30) $display("FAIL fp_beats: got %0d want 30", nb);
    else passed++;
    en0 = 0; en1 = 0;
    cycle_src(3, 1'b1);
    checks++;
    if ({cnt0_f, cnt1_f} !== {32'd10, 32'd0}) $display("FAIL fp_cnt: got %0d/%0d want 10/0", cnt0_f, cnt1_f);
    else passed++;
    use_fp = 0;
  endtask

  task automatic test_backpressure();
    int nb, bad_s1, bad_rdy;
    do_reset(); src_reset(); use_fp = 0; en0 = 1; en1 = 1;
    gap_at = 4; gap0 = 3;
    nb = 0; bad_s1 = 0; bad_rdy = 0;
    for (int c = 0; c < 80; c++) begin
      cycle_src(10, (c % 2) == 0);
      if (s1r.tready !== 1'b0) bad_s1++;
      if (c > 0 && s0r.tready !== m_rdy) bad_rdy++;
      if (mr.tvalid === 1'b1 && mr.tready === 1'b1) begin
        checks++;
        if ({mr.tdata, mr.tlast} !== {exp_dat(0, 0, nb), exp_last(nb, 10)})
          $display("FAIL bp_beat%0d: got %h/%b want %h/%b", nb, mr.tdata, mr.tlast, exp_dat(0, 0, nb), exp_last(nb, 10));
        else passed++;
        nb++;
        if (nb == 10) break;
      end
    end
    checks++;
    if (nb !== 10) $display("FAIL bp_beats: got %0d want 10", nb);
    else passed++;
    checks++;
    if (bad_s1 !== 0 || bad_rdy !== 0)
      $display("FAIL bp_ready: s1 tready high %0d cycles, s0 tready!=m tready %0d cycles, want 0/0", bad_s1, bad_rdy);
    else passed++;
    en0 = 0; en1 = 0; gap0 = 0;
    cycle_src(10, 1'b1);
    checks++;
    if ({busy_r, cnt0_r, cnt1_r} !== {1'b0, 4'd1, 4'd0})
      $display("FAIL bp_done: busy/cnt0/cnt1 got %b/%0d/%0d want 0/1/0", busy_r, cnt0_r, cnt1_r);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset(); src_reset(); use_fp = 0; en0 = 0; en1 = 1;
    for (int c = 0; c < 60; c++) begin
      cycle_src(6, 1'b1);
      if (k1 == 1 && b1 == 3) break;
    end
    checks++;
    if ({cnt1_r, mr.tdata} !== {4'd1, exp_dat(1, 1, 3)})
      $display("FAIL mid_pre: cnt1/tdata got %0d/%h want 1/%h", cnt1_r, mr.tdata, exp_dat(1, 1, 3));
    else passed++;
    sys_rst = 1'b1;
    @(posedge clk156); #1;
    @(negedge clk156);
    checks++;
    if ({busy_r, s0r.tready, s1r.tready, mr.tvalid} !== 4'b0000)
      $display("FAIL mid_abort: busy/s0rdy/s1rdy/tvalid got %b want 0000", {busy_r, s0r.tready, s1r.tready, mr.tvalid});
    else passed++;
    checks++;
    if ({cnt0_r, cnt1_r} !== 8'h00) $display("FAIL mid_cnt: got %0d/%0d want 0/0", cnt0_r, cnt1_r);
    else passed++;
    sys_rst = 1'b0; s0_vld = 1'b0; s1_vld = 1'b0;
    src_reset(); en0 = 1; en1 = 1;
    cycle_src(6, 1'b1);
    checks++;
    if (mr.tvalid !== 1'b0) $display("FAIL mid_idle: tvalid got %b want 0", mr.tvalid);
    else passed++;
    cycle_src(6, 1'b1);
    checks++;
    if ({s0r.tready, s1r.tready, mr.tdata} !== {1'b1, 1'b0, exp_dat(0, 0, 0)})
      $display("FAIL mid_regrant: s0rdy/s1rdy/tdata got %b/%b/%h want 1/0/%h", s0r.tready, s1r.tready, mr.tdata, exp_dat(0, 0, 0));
    else passed++;
  endtask

  task automatic test_wrap();
    int   cyc;
    logic seen15;
    do_reset(); src_reset(); use_fp = 0; en0 = 1; en1 = 0;
    cyc = 0; seen15 = 0;
    for (int c = 0; c < 60; c++) begin
      cycle_src(1, 1'b1);
      cyc++;
      if (k0 == 15 && !seen15) begin
        seen15 = 1;
        checks++;
        if (cnt0_r !== 4'd15) $display("FAIL wrap_15: got %0d want 15", cnt0_r);
        else passed++;
      end
      if (k0 == 16) break;
    end
    checks++;
    if (cnt0_r !== 4'd0) $display("FAIL wrap_0: got %0d want 0", cnt0_r);
    else passed++;
    checks++;
    if (cyc !== 33) $display("FAIL single_beat_rate: 16 packets took %0d cycles want 33", cyc);
    else passed++;
  endtask

  initial begin
    sys_rst = 1'b1; m_rdy = 1'b1;
    s0_vld = 1'b0; s0_dat = '0; s0_keep = '0; s0_last = 1'b0; s0_user = 1'b0;
    s1_vld = 1'b0; s1_dat = '0; s1_keep = '0; s1_last = 1'b0; s1_user = 1'b0;
    en0 = 0; en1 = 0; use_fp = 0;
    src_reset();
    test_reset();
    test_single_port();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/eth_tx_arb.md
ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 The module SHALL have parameter RR_EN, default 1, meaning 1 = round-robin between ports, 0 = fixed priority to port 0.
REQ-002 The module SHALL have parameter CNT_W, default 32, meaning width of each per-port packet counter.
REQ-003 clk156  input  1  single clock; all logic is on its rising edge.
REQ-004 sys_rst  input  1  reset, synchronous and active-high.
REQ-005 s0_axis_tvalid/tready/tdata/tkeep/tlast/tuser  input/output(tready)/input  1/1/64/8/1/1  port 0 packet stream (encapsulated Eth+IP+UDP frame source).
REQ-006 s1_axis_tvalid/tready/tdata/tkeep/tlast/tuser  input/output(tready)/input  1/1/64/8/1/1  port 1 packet stream.
REQ-007 m_axis_tvalid/tready/tdata/tkeep/tlast/tuser  output/input(tready)/output  1/1/64/8/1/1  merged stream to the 10G MAC.
REQ-008 pkt_cnt0, pkt_cnt1  output  CNT_W  packets forwarded from port 0 / port 1.
REQ-009 busy  output  1  high while a packet grant is held.

Function
REQ-010 The arbiter SHALL be a three-state machine: ARB_IDLE, ARB_P0, ARB_P1.
REQ-011 In ARB_IDLE, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, s0_axis_tready and s1_axis_tready SHALL all be 0.
REQ-012 In ARB_IDLE with only sN_axis_tvalid high, the next state SHALL be ARB_PN.
REQ-013 In ARB_IDLE with both tvalids high and RR_EN=1, the port not equal to last_grant SHALL be selected; with RR_EN=0, port 0 SHALL be selected.
REQ-014 Grant decision SHALL be registered: the first beat of a packet is presented on m_axis one cycle after the state leaves ARB_IDLE (one idle cycle of arbitration latency).
REQ-015 In ARB_PN, m_axis_tvalid/tdata/tkeep/tlast/tuser SHALL equal sN_axis_* combinationally, sN_axis_tready SHALL equal m_axis_tready, and the other port's tready SHALL be 0.
REQ-016 A beat SHALL transfer only when m_axis_tvalid and m_axis_tready are both high; deasserting sN_axis_tvalid mid-packet SHALL hold the grant (no timeout, no switch).
REQ-017 On a transferred beat with tlast=1 in ARB_PN, the next state SHALL be ARB_IDLE, last_grant SHALL become N, and pkt_cntN SHALL increment by 1.
REQ-018 Packet counters SHALL wrap modulo 2^CNT_W without saturation or flag.
REQ-019 busy SHALL be 1 in ARB_P0/ARB_P1 and 0 in ARB_IDLE.
REQ-020 tuser SHALL pass through unmodified; the arbiter SHALL NOT inspect tkeep or tuser.
REQ-021 A single-beat packet (tlast on first beat) SHALL complete in one granted cycle and return to ARB_IDLE.
REQ-022 An illegal state encoding SHALL transition to ARB_IDLE on the next clock.

Reset
REQ-023 While sys_rst is high at a clock edge, state SHALL become ARB_IDLE, pkt_cnt0 and pkt_cnt1 SHALL become 0, and last_grant SHALL become 1 (port 0 wins the first contention).
REQ-024 Reset asserted mid-packet SHALL abort the grant immediately; the partial packet is not counted and no further beats of it are forwarded.

Verification
REQ-025 Reset, then s0 sends 6-beat packet, s1 idle, m_axis_tready=1 -> m_axis_tvalid first high 1 cycle after s0_axis_tvalid, 6 beats identical to input, pkt_cnt0=1, pkt_cnt1=0, busy low after tlast.
REQ-026 RR_EN=1, both ports continuously valid with 3-beat packets -> output order P0,P1,P0,P1, one idle cycle between packets, after 4 packets pkt_cnt0=2, pkt_cnt1=2.
REQ-027 RR_EN=0, both ports continuously valid -> only port 0 packets forwarded, s1_axis_tready stays 0, pkt_cnt1=0.
REQ-028 Port 0 packet of 10 beats with m_axis_tready toggling 1,0,1,0 and s0_axis_tvalid gap of 3 cycles at beat 4 -> all 10 beats delivered in order, no port 1 beats interleaved, s0_axis_tready equals m_axis_tready throughout.
REQ-029 sys_rst pulsed at beat 3 of a port 1 packet -> next cycle busy=0, all tready 0, counters 0; following contention grants port 0.
REQ-030 pkt_cnt0 preloaded-equivalent by sending 2^CNT_W packets with CNT_W=4 -> pkt_cnt0 wraps 15 -> 0.
